// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the default MARS data-segment base address.
package dmem_pkg;

    typedef enum logic [1:0] {
        DMEM_WORD = 2'b00,
        DMEM_HALF = 2'b01,
        DMEM_BYTE = 2'b10,
        DMEM_RSVD = 2'b11
    } dmem_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data for
// writes, lane extraction plus sign/zero extension for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  dmem_type_e  acc_type,
    input  logic [1:0]  lane,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        half_sel  = lane[1] ? rword[31:16] : rword[15:0];
        byte_sel  = rword[{lane, 3'b000} +: 8];
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = '0;
        misalign  = 1'b0;
        case (acc_type)
            DMEM_WORD: begin
                byte_en   = 4'b1111;
                rdata_ext = rword;
                misalign  = (lane != 2'b00);
            end
            DMEM_HALF: begin
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{is_signed & half_sel[15]}}, half_sel};
                misalign  = lane[0];
            end
            DMEM_BYTE: begin
                byte_en   = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{is_signed & byte_sel[7]}}, byte_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_wait_responder.sv
// Data-memory responder: accepts one load/store at a time, answers after
// LATENCY cycles with a one-cycle resp_valid pulse and registered data/error.
module dmem_wait_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR
)(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_type,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d, signed_q, signed_d;
    dmem_type_e  type_q, type_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic [31:0] mem_q [DEPTH];

    logic             cur_write, cur_signed;
    dmem_type_e       cur_type;
    logic [31:0]      cur_addr, cur_wdata, offset, rword;
    logic [IDX_W-1:0] index;
    logic             out_of_range, access_err;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_rep, rdata_ext;
    logic             misalign;

    // While idle the live inputs are decoded so LATENCY=1 can build its response
    // straight from the acceptance cycle; afterwards the holding registers are used.
    always_comb begin
        cur_write    = (state_q == ST_IDLE) ? req_write              : write_q;
        cur_type     = (state_q == ST_IDLE) ? dmem_type_e'(req_type) : type_q;
        cur_signed   = (state_q == ST_IDLE) ? req_signed             : signed_q;
        cur_addr     = (state_q == ST_IDLE) ? req_addr               : addr_q;
        cur_wdata    = (state_q == ST_IDLE) ? req_wdata              : wdata_q;
        offset       = cur_addr - BASE_ADDR;
        index        = offset[IDX_W+1:2];
        out_of_range = (offset >= SPAN);
        rword        = mem_q[index];
        access_err   = (cur_type == DMEM_RSVD) | out_of_range | misalign;
    end

    dmem_lane_align u_lane_align (
        .acc_type  (cur_type),
        .lane      (offset[1:0]),
        .is_signed (cur_signed),
        .wdata     (cur_wdata),
        .rword     (rword),
        .byte_en   (byte_en),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext),
        .misalign  (misalign)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        type_d   = type_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = '0;
        error_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                write_d  = req_write;
                type_d   = dmem_type_e'(req_type);
                signed_d = req_signed;
                addr_d   = req_addr;
                wdata_d  = req_wdata;
                cnt_d    = CNT_INIT;
                state_d  = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
        // No store can land between acceptance and RESP, so the array is read on entry to RESP.
        if (state_d == ST_RESP && state_q != ST_RESP) begin
            error_d = access_err;
            rdata_d = (access_err || cur_write) ? '0 : rdata_ext;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            type_q   <= DMEM_WORD;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            type_q   <= type_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    // NOTE: the array has no reset; contents must survive reset and clearing it would cost a full reset tree.
    always_ff @(posedge clock) begin
        if (reset_n && state_q == ST_RESP && write_q && !access_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem_q[index][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

endmodule

// File: doc/dmem_wait_responder.md
# dmem_wait_responder

Data-memory responder for the five-stage pipeline. It accepts word, halfword and byte load/store requests issued by the memory stage. It translates the MARS-style data byte address (base 0x10010000) into an array index and answers each request after a programmable latency using a valid/ready handshake. The pipeline stalls on `req_ready`/`resp_valid` instead of assuming a single-cycle memory.

## Interface
- `DEPTH`, 1024: number of 32-bit words in the array (power of two).
- `LATENCY`, 2: cycles from request acceptance to response; legal range 1–15.
- `BASE_ADDR`, 32'h10010000: byte address of word 0.

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  memory stage presents a request.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_type`  in  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  32  byte address (the ALU result).
- `req_wdata`  in  32  store data; the value is taken from the low bytes.
- `resp_valid`  out  1  one-cycle pulse: response for the accepted request.
- `resp_rdata`  out  32  load data, aligned and extended; 0 for stores and errors.
- `resp_error`  out  1  valid with `resp_valid`: misaligned, out-of-range or reserved type.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - When `req_valid`=1, all request fields are captured into holding registers, the down-counter is loaded with `LATENCY`-1, and the FSM goes to WAIT, or to RESP directly if `LATENCY`=1.
- WAIT:
  - `req_ready`=0 and the counter decrements.
  - When the counter reaches 0, the FSM goes to RESP.
- RESP:
  - `resp_valid`=1 for exactly one cycle, then the FSM returns to IDLE.
  - `req_ready`=0 in RESP, so there are no back-to-back acceptances. Maximum throughput is one request per `LATENCY`+1 cycles.
- Address translation:
  - offset = addr − `BASE_ADDR`, 32-bit unsigned subtraction.
  - index = offset[31:2]; lane = offset[1:0].
  - Out of range when offset ≥ 4·`DEPTH`; an address below the base wraps to a large offset and is therefore out of range.
- Alignment: word requires lane=00; halfword requires lane[0]=0; byte accepts any lane.
- Error priority: reserved type, then out-of-range, then misaligned.
  - Any error sets `resp_error`=1 and `resp_rdata`=0.
  - A store with an error performs no array write.
- Store:
  - Byte enables are derived from type and lane (little-endian).
  - Word writes all 4 bytes.
  - Halfword writes bytes lane..lane+1 from `req_wdata`[15:0].
  - Byte writes byte lane from `req_wdata`[7:0].
  - The write commits on the clock edge that ends the RESP cycle; unselected bytes are unchanged.
- Load:
  - The array is read at the captured index.
  - The selected byte or halfword is shifted to bit 0 and extended per `req_signed`; a word load returns as-is.
- Reset:
  - FSM to IDLE, counter and holding registers to 0.
  - Outputs: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0.
  - Array contents are not cleared.
  - Reset during WAIT or RESP abandons the request, and a pending store is not written.

## Timing
- Acceptance cycle t: `req_valid`=1 while `req_ready`=1.
- `resp_valid` is high in cycle t+`LATENCY`, and `req_ready` returns to 1 in cycle t+`LATENCY`+1.
- Request inputs are sampled only in the acceptance cycle; they may change freely afterwards.
- `resp_rdata` and `resp_error` are registered and stable for the whole RESP cycle. Outside RESP they are 0.
- Read data reflects all stores completed before the acceptance edge.
- A load accepted in the cycle after a store's RESP sees the stored value.

## Structure
- Package `dmem_pkg`:
  - Access-type encodings: `DMEM_WORD`, `DMEM_HALF`, `DMEM_BYTE`, `DMEM_RSVD`.
  - FSM state enum `{ST_IDLE, ST_WAIT, ST_RESP}`.
  - Default `BASE_ADDR` constant.
- Sub-module `dmem_lane_align` (combinational):
  - Inputs: type, lane, signed flag, write data, read word.
  - Outputs: 4-bit byte enable, lane-replicated write data, extended load data, misalign flag.
- The top level holds the FSM, counter, holding registers and array.

## Test plan
- Reset, then word store 0xDEADBEEF to 0x10010004 with `LATENCY`=2, then word load from 0x10010004 → `resp_valid` exactly 2 cycles after each acceptance; load returns 0xDEADBEEF with `resp_error`=0.
- Byte store 0x80 to 0x10010005, then signed byte load → 0xFFFFFF80; unsigned load → 0x00000080; word load at 0x10010004 → 0xDEAD80EF.
- Halfword load from 0x10010003 → `resp_error`=1, `resp_rdata`=0. A word store to 0x10010002 → error, and the word at index 0 is unchanged.
- Address 0x1000FFFC, and 0x10010000+4·`DEPTH` → `resp_error`=1 in both cases. `req_type`=11 → error.
- `req_valid` held high continuously with `LATENCY`=1 → accepted every 2nd cycle and `req_ready` low in each RESP cycle. With `LATENCY`=15, the response arrives exactly 15 cycles after acceptance.
- Store accepted, then `reset_n`=0 during WAIT → no `resp_valid`, outputs at reset values; a subsequent load shows the old contents.
